// File: rtl/pool_obuf_pkg.sv
// Shared defaults for the binary CNN layers (window buffer, conv, pooling).
// Contents:
//   DEF_IMG_DIM, DEF_KERNEL_DIM, DEF_CHANNELS, DEF_FIFO_DEPTH - default geometry
//   out_dim()  - side length of a valid (no padding) windowed output map
package pool_obuf_pkg;

    localparam int DEF_IMG_DIM    = 28;
    localparam int DEF_KERNEL_DIM = 2;
    localparam int DEF_CHANNELS   = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    // Number of window positions along one axis when the window never
    // leaves the image. Only ever evaluated at elaboration time.
    function automatic int out_dim(input int img_dim, input int kernel_dim, input int stride);
        return (img_dim - kernel_dim) / stride + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (empties the FIFO)
//   push       - write push_data this cycle (ignored while full)
//   push_data  - entry to write
//   full       - occupancy == DEPTH
//   pop        - consume the head entry this cycle (ignored while empty)
//   empty      - occupancy == 0
//   head       - oldest entry, driven straight from the storage registers
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    // DEPTH is a power of two, so the pointers wrap on their own.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    // No bypass: a push into a full FIFO is refused even if a pop happens.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pool_obuf.sv
// Pooling output stage: tracks the raster position of each incoming pixel,
// keeps only pixels that close a pooling window on the stride grid, and
// queues those pooled values (with an end-of-frame flag) for downstream.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_valid   - a pixel enters the line buffer this cycle
//   i_data    - OR-pooled window whose bottom-right corner is that pixel
//   i_ready   - a pixel can be accepted this cycle
//   o_valid   - o_data / o_last hold a pooled output
//   o_data    - pooled output pixel
//   o_last    - final pooled pixel of the frame
//   o_ready   - downstream takes the output this cycle
module pool_obuf
    import pool_obuf_pkg::*;
#(
    parameter int IMG_DIM    = DEF_IMG_DIM,
    parameter int KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int STRIDE     = KERNEL_DIM,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [CHANNELS-1:0] i_data,
    output logic                i_ready,
    output logic                o_valid,
    output logic [CHANNELS-1:0] o_data,
    output logic                o_last,
    input  logic                o_ready
);

    localparam int OUT_DIM = out_dim(IMG_DIM, KERNEL_DIM, STRIDE);
    localparam int PW      = $clog2(IMG_DIM);
    localparam int SW      = $clog2(STRIDE) + 1;

    localparam logic [PW-1:0] POS_MAX   = PW'(IMG_DIM - 1);
    localparam logic [PW-1:0] POS_FIRST = PW'(KERNEL_DIM - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(KERNEL_DIM - 1 + (OUT_DIM - 1) * STRIDE);
    localparam logic [SW-1:0] PH_MAX    = SW'(STRIDE - 1);

    logic [PW-1:0]       col;
    logic [PW-1:0]       row;
    logic [SW-1:0]       col_ph;
    logic [SW-1:0]       row_ph;
    logic                rdy_en;
    logic                fifo_full;
    logic                fifo_empty;
    logic                xfer;
    logic                emit;
    logic                last;
    logic [CHANNELS:0]   head;

    // Held low through reset and for the first edge after it.
    assign i_ready = rdy_en && !fifo_full;
    assign xfer    = i_valid && i_ready;

    // A phase of zero past the first full window marks a stride-grid
    // position; the phase counters replace a modulo on col/row.
    assign emit = (col >= POS_FIRST) && (row >= POS_FIRST) &&
                  (col_ph == '0) && (row_ph == '0);
    assign last = emit && (col == POS_LAST) && (row == POS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Position and phase advance only on an accepted pixel. Phases stay at
    // zero until the first full window, then cycle 0..STRIDE-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (xfer) begin
            if (col == POS_MAX) begin
                col    <= '0;
                col_ph <= '0;
                if (row == POS_MAX) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row <= row + 1'b1;
                    if (row >= POS_FIRST) begin
                        row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + 1'b1;
                    end
                end
            end else begin
                col <= col + 1'b1;
                if (col >= POS_FIRST) begin
                    col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (CHANNELS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer && emit),
        .push_data ({i_data, last}),
        .full      (fifo_full),
        .pop       (o_ready),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign o_valid = !fifo_empty;
    assign o_data  = head[CHANNELS:1];
    assign o_last  = head[0];

endmodule

// File: tb/tb_pool_obuf.sv
module tb_pool_obuf;

    localparam int IMG  = 28;
    localparam int K    = 2;
    localparam int S    = 2;
    localparam int OUTD = 14;
    localparam int K3   = 3;
    localparam int OUT3 = 9;
    localparam int CH3  = 10;
    localparam int NPIX = IMG * IMG;

    localparam int M_PLAIN  = 0;
    localparam int M_EMIT   = 1;
    localparam int M_DIRECT = 2;
    localparam int M_STALL  = 3;
    localparam int M_RAND   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           i_valid = 1'b0;
    logic [0:0]     i_data  = '0;
    logic           i_ready;
    logic           o_valid;
    logic [0:0]     o_data;
    logic           o_last;
    logic           o_ready;

    logic           t_valid = 1'b0;
    logic [CH3-1:0] t_idata = '0;
    logic           t_ready;
    logic           t_ovalid;
    logic [CH3-1:0] t_odata;
    logic           t_olast;
    logic           t_oready;

    pool_obuf dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_ready (o_ready)
    );

    pool_obuf #(
        .IMG_DIM    (IMG),
        .KERNEL_DIM (K3),
        .STRIDE     (K3),
        .CHANNELS   (CH3),
        .FIFO_DEPTH (4)
    ) dut3 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (t_valid),
        .i_data  (t_idata),
        .i_ready (t_ready),
        .o_valid (t_ovalid),
        .o_data  (t_odata),
        .o_last  (t_olast),
        .o_ready (t_oready)
    );

    typedef struct {
        logic [CH3-1:0] d;
        logic           l;
    } exp_t;

    exp_t q_main[$];
    exp_t q_k3[$];

    int   checks = 0;
    int   errors = 0;
    int   outs_main = 0;
    int   lasts_main = 0;
    int   outs_k3 = 0;
    int   lasts_k3 = 0;
    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;
    logic img [IMG][IMG];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        $display("FAIL %s: DUT did not respond within the cycle budget", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "run stopped");
    endtask

    // Reference: emitting positions and block values straight from the rules.
    function automatic bit is_emit(input int r, input int c, input int k, input int s);
        return (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
    endfunction

    function automatic logic win_or(input int r, input int c);
        logic v;
        v = 1'b0;
        for (int a = r - K + 1; a <= r; a++)
            for (int b = c - K + 1; b <= c; b++)
                v = v | img[a][b];
        return v;
    endfunction

    task automatic gen_frame();
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                img[r][c] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < OUTD; i++)
            for (int j = 0; j < OUTD; j++)
                q_main.push_back('{d: CH3'(win_or(i * S + K - 1, j * S + K - 1)),
                                   l: (i == OUTD - 1) && (j == OUTD - 1)});
    endtask

    // o_ready / t_oready are written only here, 2 time units after each edge.
    initial begin
        o_ready  = 1'b0;
        t_oready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            o_ready  = rand_ready ? 1'($urandom) : ready_force;
            t_oready = rand_ready ? 1'($urandom) : ready_force;
        end
    end

    initial begin : mon_main
        bit   hold;
        logic hd;
        logic hl;
        exp_t e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(o_valid), 32'd1);
                    check("hold_data", 32'({o_data, o_last}), 32'({hd, hl}));
                end
                hold = o_valid && !o_ready;
                hd   = o_data[0];
                hl   = o_last;
                if (o_valid && o_ready) begin
                    if (q_main.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got data %0h last %0b, expected no output", o_data, o_last);
                    end else begin
                        e = q_main.pop_front();
                        check("out_data", 32'(o_data), 32'(e.d));
                        check("out_last", 32'(o_last), 32'(e.l));
                    end
                    outs_main++;
                    if (o_last) lasts_main++;
                end
            end
        end
    end

    initial begin : mon_k3
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && t_ovalid && t_oready) begin
                if (q_k3.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL k3_unexpected: got data %0h last %0b, expected no output", t_odata, t_olast);
                end else begin
                    e = q_k3.pop_front();
                    check("k3_pos", 32'(t_odata), 32'(e.d));
                    check("k3_last", 32'(t_olast), 32'(e.l));
                end
                outs_k3++;
                if (t_olast) lasts_k3++;
            end
        end
    end

    // Present one pixel and hold it until accepted; returns at edge+1.
    task automatic drive_main(input logic d, input int release_after, output int stalls);
        i_valid = 1'b1;
        i_data  = d;
        stalls  = 0;
        forever begin
            @(negedge clk);
            if (i_ready) break;
            stalls++;
            if (release_after > 0 && stalls == 3)
                check("stall_buffered", 32'(o_valid), 32'd1);
            if (release_after > 0 && stalls == release_after) ready_force = 1'b1;
            if (stalls > 300) abort("in_accept");
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int count);
        int first_stall;
        first_stall = -1;
        gen_frame();
        for (int n = 0; n < count; n++) begin
            int   r;
            int   c;
            int   st;
            logic d;
            r = n / IMG;
            c = n % IMG;
            d = (r >= K - 1 && c >= K - 1) ? win_or(r, c) : 1'($urandom);
            if (mode == M_RAND) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (mode == M_DIRECT) ready_force = (n >= 31);
            drive_main(d, (mode == M_STALL) ? 6 : 0, st);
            if (mode == M_EMIT) begin
                check("emit_valid", 32'(o_valid), 32'(is_emit(r, c, K, S)));
                check("emit_last", 32'(o_valid && o_last), 32'(n == NPIX - 1));
            end
            if (mode == M_DIRECT && n == 30) begin
                check("one_entry_valid", 32'(o_valid), 32'd1);
                check("one_entry_data", 32'(o_data), 32'(win_or(1, 1)));
            end
            if (mode == M_DIRECT && n == 31) begin
                check("pushpop_valid", 32'(o_valid), 32'd1);
                check("pushpop_data", 32'(o_data), 32'(win_or(1, 3)));
            end
            if (st > 0 && first_stall < 0) first_stall = n;
        end
        if (mode == M_STALL) check("stall_first_idx", 32'(first_stall), 32'd36);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q_main.size() != 0 || q_k3.size() != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) abort("drain");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drive_k3(input int r, input int c);
        int stalls;
        t_valid = 1'b1;
        t_idata = {5'(r), 5'(c)};
        stalls  = 0;
        forever begin
            @(negedge clk);
            if (t_ready) break;
            stalls++;
            if (stalls > 300) abort("k3_accept");
        end
        @(posedge clk);
        #1;
        t_valid = 1'b0;
    endtask

    initial begin : main
        int o0;
        int l0;
        #2;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_i_ready_early", 32'(i_ready), 32'd0);
        @(negedge clk);
        check("rel_i_ready", 32'(i_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back frame with downstream always ready.
        ready_force = 1'b1;
        o0 = outs_main; l0 = lasts_main;
        run_frame(M_EMIT, NPIX);
        wait_drain();
        check("t1_outputs", 32'(outs_main - o0), 32'(OUTD * OUTD));
        check("t1_lasts", 32'(lasts_main - l0), 32'd1);

        // One buffered entry, then push and pop on the same edge.
        run_frame(M_DIRECT, NPIX);
        ready_force = 1'b1;
        wait_drain();

        // Downstream stalled: FIFO fills, input back-pressured, then released.
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o0 = outs_main; l0 = lasts_main;
        run_frame(M_STALL, NPIX);
        wait_drain();
        check("t2_outputs", 32'(outs_main - o0), 32'(OUTD * OUTD));
        check("t2_lasts", 32'(lasts_main - l0), 32'd1);

        // Random input gaps and random downstream readiness over 3 frames.
        rand_ready = 1'b1;
        o0 = outs_main; l0 = lasts_main;
        repeat (3) run_frame(M_RAND, NPIX);
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        wait_drain();
        check("t3_outputs", 32'(outs_main - o0), 32'(3 * OUTD * OUTD));
        check("t3_lasts", 32'(lasts_main - l0), 32'd3);

        // Reset in mid-frame, then a complete fresh frame.
        run_frame(M_PLAIN, 400);
        rst = 1'b1;
        #1;
        check("mid_rst_o_valid", 32'(o_valid), 32'd0);
        check("mid_rst_o_last", 32'(o_last), 32'd0);
        check("mid_rst_o_data", 32'(o_data), 32'd0);
        q_main.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_i_ready_early", 32'(i_ready), 32'd0);
        @(posedge clk);
        #1;
        o0 = outs_main; l0 = lasts_main;
        run_frame(M_PLAIN, NPIX);
        wait_drain();
        check("t4_outputs", 32'(outs_main - o0), 32'(OUTD * OUTD));
        check("t4_lasts", 32'(lasts_main - l0), 32'd1);

        // 3x3 window, stride 3: output data carries the emitting position.
        for (int i = 0; i < OUT3; i++)
            for (int j = 0; j < OUT3; j++)
                q_k3.push_back('{d: {5'(2 + 3 * i), 5'(2 + 3 * j)},
                                 l: (i == OUT3 - 1) && (j == OUT3 - 1)});
        rand_ready = 1'b1;
        o0 = outs_k3; l0 = lasts_k3;
        for (int n = 0; n < NPIX; n++) drive_k3(n / IMG, n % IMG);
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        wait_drain();
        check("k3_outputs", 32'(outs_k3 - o0), 32'(OUT3 * OUT3));
        check("k3_lasts", 32'(lasts_k3 - l0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : guard
        #1500000;
        abort("global_timeout");
    end

endmodule
